// File: rtl/alu_acc_seq.sv
// Accumulator/sequencer stage around the external 16-bit ALU adder.
// Accepts one op + operand, drives the adder for a single EXEC cycle,
// captures sum and flags into the accumulator/status registers, then
// presents the result on a valid/ready response channel.
module alu_acc_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_sticky,
  // adder interface
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  input  logic             add_sign,
  input  logic             add_zero,
  input  logic             add_parity,
  input  logic             add_ovf,
  // response channel
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  // architectural state
  output logic [WIDTH-1:0] acc,
  output logic [4:0]       flags,
  output logic             sticky_ovf
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpAdc  = 2'b10;
  localparam logic [1:0] OpSub  = 2'b11;

  // flags layout: {C, S, Z, P, V}
  localparam int unsigned FlagC = 4;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q;
  logic             is_load_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic             add_cin_q;
  logic [WIDTH-1:0] acc_q;
  logic [4:0]       flags_q;
  logic             sticky_q;
  logic             ovf_capture;

  // LOAD forces V to 0, so only arithmetic ops can raise the sticky bit.
  assign ovf_capture = (state_q == StExec) && !is_load_q && add_ovf;

  // Sequencer FSM: registers operands, drives the adder, captures the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_load_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      acc_q       <= '0;
      flags_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            is_load_q  <= (in_op == OpLoad);
            in_ready_q <= 1'b0;
            state_q    <= StExec;
            case (in_op)
              OpLoad: begin
                add_a_q   <= '0;
                add_b_q   <= in_data;
                add_cin_q <= 1'b0;
              end
              OpAdd: begin
                add_a_q   <= acc_q;
                add_b_q   <= in_data;
                add_cin_q <= 1'b0;
              end
              OpAdc: begin
                add_a_q   <= acc_q;
                add_b_q   <= in_data;
                add_cin_q <= flags_q[FlagC];
              end
              OpSub: begin
                // acc + ~data + 1; C=1 means no borrow
                add_a_q   <= acc_q;
                add_b_q   <= ~in_data;
                add_cin_q <= 1'b1;
              end
              default: begin
                add_a_q   <= '0;
                add_b_q   <= '0;
                add_cin_q <= 1'b0;
              end
            endcase
          end
        end
        StExec: begin
          acc_q       <= add_s;
          flags_q     <= {add_cout & ~is_load_q, add_sign, add_zero, add_parity,
                          add_ovf & ~is_load_q};
          add_a_q     <= '0;
          add_b_q     <= '0;
          add_cin_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // Sticky overflow: a capture with V=1 beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (ovf_capture) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = acc_q;
  assign acc        = acc_q;
  assign flags      = flags_q;
  assign sticky_ovf = sticky_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq; includes a behavioural model of the adder.
module tb_alu_acc_seq;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             clr_sticky;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             add_sign;
  logic             add_zero;
  logic             add_parity;
  logic             add_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] acc;
  logic [4:0]       flags;
  logic             sticky_ovf;

  int tests = 0;
  int fails = 0;

  // model state for operand expectations
  logic [15:0] m_acc = 16'h0;
  logic        m_c   = 1'b0;

  always #5 clk = ~clk;

  // external adder model
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};
  assign add_sign   = add_s[15];
  assign add_zero   = ~|add_s;
  assign add_parity = ~^add_s;
  assign add_ovf    = (add_a[15] == add_b[15]) && (add_s[15] != add_a[15]);

  alu_acc_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .clr_sticky (clr_sticky),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_s      (add_s),
    .add_cout   (add_cout),
    .add_sign   (add_sign),
    .add_zero   (add_zero),
    .add_parity (add_parity),
    .add_ovf    (add_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .acc        (acc),
    .flags      (flags),
    .sticky_ovf (sticky_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction; stall = cycles out_ready is held low in RESP.
  task automatic run_op(input logic [1:0] op, input logic [15:0] data,
                        input logic [15:0] exp_acc, input logic [4:0] exp_flags,
                        input logic exp_sticky, input int stall);
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ec;
    ea = (op == 2'b00) ? 16'h0 : m_acc;
    eb = (op == 2'b11) ? ~data : data;
    ec = (op == 2'b11) ? 1'b1 : ((op == 2'b10) ? m_c : 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = data;
    out_ready = 1'b0;
    check("idle_in_ready", {31'h0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("exec_in_ready", {31'h0, in_ready}, 32'd0);
    check("exec_out_valid", {31'h0, out_valid}, 32'd0);
    check("exec_add_a", {16'h0, add_a}, {16'h0, ea});
    check("exec_add_b", {16'h0, add_b}, {16'h0, eb});
    check("exec_add_cin", {31'h0, add_cin}, {31'h0, ec});
    @(negedge clk);
    check("resp_out_valid", {31'h0, out_valid}, 32'd1);
    check("resp_in_ready", {31'h0, in_ready}, 32'd0);
    check("resp_out_data", {16'h0, out_data}, {16'h0, exp_acc});
    check("resp_acc", {16'h0, acc}, {16'h0, exp_acc});
    check("resp_flags", {27'h0, flags}, {27'h0, exp_flags});
    check("resp_sticky", {31'h0, sticky_ovf}, {31'h0, exp_sticky});
    check("resp_add_a_zero", {16'h0, add_a}, 32'd0);
    if (stall > 0) begin
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_data  = 16'h1111;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
      check("stall_out_data", {16'h0, out_data}, {16'h0, exp_acc});
      check("stall_in_ready", {31'h0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("done_out_valid", {31'h0, out_valid}, 32'd0);
    check("done_in_ready", {31'h0, in_ready}, 32'd1);
    check("done_acc", {16'h0, acc}, {16'h0, exp_acc});
    m_acc = exp_acc;
    m_c   = exp_flags[4];
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_data    = 16'h0;
    clr_sticky = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_acc", {16'h0, acc}, 32'd0);
    check("rst_flags", {27'h0, flags}, 32'd0);
    check("rst_sticky", {31'h0, sticky_ovf}, 32'd0);
    check("rst_add_a", {16'h0, add_a}, 32'd0);
    check("rst_add_b", {16'h0, add_b}, 32'd0);
    check("rst_add_cin", {31'h0, add_cin}, 32'd0);

    // 1: LOAD, 5 ones -> odd parity
    run_op(2'b00, 16'h1234, 16'h1234, 5'b00000, 1'b0, 0);

    // 2: wrap to zero with carry out
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 5'b01010, 1'b0, 0);
    run_op(2'b01, 16'h0001, 16'h0000, 5'b10110, 1'b0, 0);

    // 3: signed overflow sets sticky, clr_sticky clears it
    run_op(2'b00, 16'h7FFF, 16'h7FFF, 5'b00000, 1'b0, 0);
    run_op(2'b01, 16'h0001, 16'h8000, 5'b01001, 1'b1, 0);
    check("sticky_held", {31'h0, sticky_ovf}, 32'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("sticky_cleared", {31'h0, sticky_ovf}, 32'd0);

    // 3b: set wins over a simultaneous clear
    run_op(2'b00, 16'h7FFF, 16'h7FFF, 5'b00000, 1'b0, 0);
    clr_sticky = 1'b1;
    run_op(2'b01, 16'h0001, 16'h8000, 5'b01001, 1'b1, 0);
    check("sticky_clr_after", {31'h0, sticky_ovf}, 32'd0);
    clr_sticky = 1'b0;

    // 4: ADC uses stored carry; SUB borrow
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 5'b01010, 1'b0, 0);
    run_op(2'b01, 16'h0001, 16'h0000, 5'b10110, 1'b0, 0);
    run_op(2'b10, 16'h0005, 16'h0006, 5'b00010, 1'b0, 0);
    run_op(2'b00, 16'h0005, 16'h0005, 5'b00010, 1'b0, 0);
    run_op(2'b11, 16'h0007, 16'hFFFE, 5'b01000, 1'b0, 0);

    // 5: response stall, new request must not be accepted
    run_op(2'b00, 16'hA5A5, 16'hA5A5, 5'b01010, 1'b0, 4);
    @(negedge clk);
    check("stall_no_accept_acc", {16'h0, acc}, 32'h0000_A5A5);
    check("stall_no_accept_valid", {31'h0, out_valid}, 32'd0);

    // 6: reset during EXEC discards the ADD
    run_op(2'b00, 16'h7FFF, 16'h7FFF, 5'b00000, 1'b0, 0);
    run_op(2'b01, 16'h0001, 16'h8000, 5'b01001, 1'b1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 16'h0010;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_exec", {31'h0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst6_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst6_acc", {16'h0, acc}, 32'd0);
    check("rst6_flags", {27'h0, flags}, 32'd0);
    check("rst6_sticky", {31'h0, sticky_ovf}, 32'd0);
    check("rst6_add_b", {16'h0, add_b}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst6_no_valid", {31'h0, out_valid}, 32'd0);
    end
    m_acc = 16'h0;
    m_c   = 1'b0;
    run_op(2'b00, 16'h0042, 16'h0042, 5'b00010, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
